// File: rtl/irda_fir_rx_datapath_if.sv
// -----------------------------------------------------------------------------
// irda_fir_rx_datapath_if
// Groups the strobes, control inputs and observable outputs of the FIR receive
// datapath. The clock and the reset are plain ports on the block, not members.
//   master : drives the strobes, rx_i, fd_o and CRC controls; observes outputs
//   slave  : the datapath itself
// Members:
//   fast_enable     oversample strobe (4 per chip)
//   fir_rx8_enable  chip strobe
//   fir_rx4_enable  bit strobe (every second chip strobe)
//   fir_rx_restart  synchronous restart of bit sync and 4PPM decoder
//   rx_i            raw IR input, 1 = pulse
//   bs_o            synchronized chip value
//   fd_o            symbol-aligned chip stream from the flag detector
//   clrcrc          synchronous CRC preset
//   crcndata        1 = shift CRC out on txdout (optional feature only)
//   bdcrc           1 = invert shifted CRC (optional feature only)
//   ppmd_o          decoded serial data bit
//   ppmd_bad_chip   sticky invalid-symbol flag
//   txdout          CRC block serial output
//   crc32_par_o     CRC register
//   crc_ok          CRC register equals the good-frame residue
// -----------------------------------------------------------------------------
interface irda_fir_rx_datapath_if;
  logic        fast_enable;
  logic        fir_rx8_enable;
  logic        fir_rx4_enable;
  logic        fir_rx_restart;
  logic        rx_i;
  logic        bs_o;
  logic        fd_o;
  logic        clrcrc;
  logic        crcndata;
  logic        bdcrc;
  logic        ppmd_o;
  logic        ppmd_bad_chip;
  logic        txdout;
  logic [31:0] crc32_par_o;
  logic        crc_ok;

  modport master (
    output fast_enable, fir_rx8_enable, fir_rx4_enable, fir_rx_restart,
    output rx_i, fd_o, clrcrc, crcndata, bdcrc,
    input  bs_o, ppmd_o, ppmd_bad_chip, txdout, crc32_par_o, crc_ok
  );

  modport slave (
    input  fast_enable, fir_rx8_enable, fir_rx4_enable, fir_rx_restart,
    input  rx_i, fd_o, clrcrc, crcndata, bdcrc,
    output bs_o, ppmd_o, ppmd_bad_chip, txdout, crc32_par_o, crc_ok
  );
endinterface

// File: rtl/irda_fir_rx_datapath.sv
// -----------------------------------------------------------------------------
// irda_fir_rx_datapath
// FIR (4 Mb/s, 4PPM) receive datapath: bit synchronizer -> 4PPM decoder ->
// CRC32 accumulator.
// Ports:
//   clk       system clock
//   wb_rst_i  asynchronous active-high reset
//   bus       irda_fir_rx_datapath_if.slave (strobes, rx_i, fd_o, CRC controls,
//             bs_o, ppmd_o, ppmd_bad_chip, txdout, crc32_par_o, crc_ok)
// Parameter:
//   CRC_RESIDUE  CRC register value after a good frame including its FCS
// Build option:
//   IRDA_CRC_TXOUT_EN  when defined, crcndata=1 shifts the (optionally
//                      inverted) CRC out on txdout instead of accumulating data.
//                      When undefined, crcndata and bdcrc are ignored.
// -----------------------------------------------------------------------------
module irda_fir_rx_datapath #(
  parameter logic [31:0] CRC_RESIDUE = 32'hC704DD7B
) (
  input  logic                    clk,
  input  logic                    wb_rst_i,
  irda_fir_rx_datapath_if.slave   bus
);

  localparam logic [31:0] CRC_POLY   = 32'h04C11DB7;
  localparam logic [31:0] CRC_PRESET = 32'hFFFF_FFFF;

  // One MSB-first LFSR step of CRC32 for a single serial data bit.
  function automatic logic [31:0] crc32_step(input logic [31:0] crc, input logic din);
    logic fb;
    fb = crc[31] ^ din;
    crc32_step = {crc[30:0], 1'b0} ^ (fb ? CRC_POLY : 32'h0000_0000);
  endfunction

  // 4PPM symbol decode, result is {bad, b1, b0}; invalid symbols decode to 00.
  function automatic logic [2:0] ppm_decode(input logic [3:0] sym);
    case (sym)
      4'b1000: ppm_decode = 3'b000;
      4'b0100: ppm_decode = 3'b001;
      4'b0010: ppm_decode = 3'b010;
      4'b0001: ppm_decode = 3'b011;
      default: ppm_decode = 3'b100;
    endcase
  endfunction

  // Bit synchronizer state
  logic        rx_meta_q, rx_sync_q;
  logic        prev_q, prev_d;
  logic [1:0]  phase_q, phase_d;
  logic        bs_q, bs_d;

  // 4PPM decoder state
  logic [3:0]  chip_sr_q, chip_sr_d;
  logic [1:0]  cc_q, cc_d;
  logic [1:0]  hold_q, hold_d;
  logic        sel_q, sel_d;      // 0 = b0 goes out next, 1 = b1
  logic        ppmd_q, ppmd_d;
  logic        bad_q, bad_d;

  // CRC block state
  logic [31:0] crc_q, crc_d;
  logic        txd_q, txd_d;

  // Completed symbol as seen on the chip strobe that ends it.
  logic [3:0]  sym_s;
  logic [2:0]  dec_s;
  logic [31:0] crc_upd_s;

  assign sym_s     = {chip_sr_q[2:0], bus.fd_o};
  assign dec_s     = ppm_decode(sym_s);
  assign crc_upd_s = crc32_step(crc_q, ppmd_q);

  // Bit synchronizer: phase tracking and mid-chip sampling on the oversample strobe
  always_comb begin
    prev_d  = prev_q;
    phase_d = phase_q;
    bs_d    = bs_q;
    if (bus.fir_rx_restart) begin
      prev_d  = 1'b0;
      phase_d = 2'd0;
      bs_d    = 1'b0;
    end else if (bus.fast_enable) begin
      prev_d = rx_sync_q;
      // An edge marks the first sample of a chip, so phase 2 is its middle.
      if (rx_sync_q != prev_q) begin
        phase_d = 2'd1;
      end else begin
        phase_d = phase_q + 2'd1;
      end
      if (phase_q == 2'd2) begin
        bs_d = rx_sync_q;
      end else begin
        bs_d = bs_q;
      end
    end else begin
      prev_d = prev_q;
    end
  end

  // 4PPM chip capture, symbol decode and serialisation of the held dibit
  always_comb begin
    chip_sr_d = chip_sr_q;
    cc_d      = cc_q;
    hold_d    = hold_q;
    sel_d     = sel_q;
    ppmd_d    = ppmd_q;
    bad_d     = bad_q;
    if (bus.fir_rx_restart) begin
      chip_sr_d = 4'b0000;
      cc_d      = 2'd0;
      hold_d    = 2'b00;
      sel_d     = 1'b0;
      ppmd_d    = 1'b0;
      bad_d     = 1'b0;
    end else begin
      if (bus.fir_rx4_enable) begin
        ppmd_d = sel_q ? hold_q[1] : hold_q[0];
        sel_d  = ~sel_q;
      end else begin
        ppmd_d = ppmd_q;
      end
      if (bus.fir_rx8_enable) begin
        chip_sr_d = sym_s;
        cc_d      = cc_q + 2'd1;
        // Loading a new dibit restarts serialisation at b0, even if a bit
        // strobe in this same cycle just emitted b1 of the previous symbol.
        if (cc_q == 2'd3) begin
          hold_d = dec_s[1:0];
          sel_d  = 1'b0;
          bad_d  = bad_q | dec_s[2];
        end else begin
          hold_d = hold_q;
        end
      end else begin
        chip_sr_d = chip_sr_q;
      end
    end
  end

  // CRC32 accumulation / shift-out and serial output register
  always_comb begin
    crc_d = crc_q;
    txd_d = txd_q;
    if (bus.fir_rx4_enable) begin
`ifdef IRDA_CRC_TXOUT_EN
      if (bus.crcndata) begin
        txd_d = ~crc_q[31] ^ bus.bdcrc;
        crc_d = {crc_q[30:0], 1'b1};
      end else begin
        txd_d = ppmd_q;
        crc_d = crc_upd_s;
      end
`else
      txd_d = ppmd_q;
      crc_d = crc_upd_s;
`endif
    end else begin
      txd_d = txd_q;
    end
    // Preset overrides any same-cycle update.
    if (bus.clrcrc) begin
      crc_d = CRC_PRESET;
    end else begin
      txd_d = txd_d;
    end
  end

`ifndef IRDA_CRC_TXOUT_EN
  logic unused_ctrl_s;
  assign unused_ctrl_s = bus.crcndata ^ bus.bdcrc;
`endif

  // All state flops; the input synchronizer runs every clock
  always_ff @(posedge clk or posedge wb_rst_i) begin
    if (wb_rst_i) begin
      rx_meta_q <= 1'b0;
      rx_sync_q <= 1'b0;
      prev_q    <= 1'b0;
      phase_q   <= 2'd0;
      bs_q      <= 1'b0;
      chip_sr_q <= 4'b0000;
      cc_q      <= 2'd0;
      hold_q    <= 2'b00;
      sel_q     <= 1'b0;
      ppmd_q    <= 1'b0;
      bad_q     <= 1'b0;
      crc_q     <= CRC_PRESET;
      txd_q     <= 1'b0;
    end else begin
      rx_meta_q <= bus.rx_i;
      rx_sync_q <= rx_meta_q;
      prev_q    <= prev_d;
      phase_q   <= phase_d;
      bs_q      <= bs_d;
      chip_sr_q <= chip_sr_d;
      cc_q      <= cc_d;
      hold_q    <= hold_d;
      sel_q     <= sel_d;
      ppmd_q    <= ppmd_d;
      bad_q     <= bad_d;
      crc_q     <= crc_d;
      txd_q     <= txd_d;
    end
  end

  assign bus.bs_o          = bs_q;
  assign bus.ppmd_o        = ppmd_q;
  assign bus.ppmd_bad_chip = bad_q;
  assign bus.txdout        = txd_q;
  assign bus.crc32_par_o   = crc_q;
  assign bus.crc_ok        = (crc_q == CRC_RESIDUE);

endmodule

// File: tb/tb_irda_fir_rx_datapath.sv
module tb_irda_fir_rx_datapath;

  logic clk = 1'b0;
  logic wb_rst_i;

  irda_fir_rx_datapath_if bus ();

  irda_fir_rx_datapath dut (
    .clk      (clk),
    .wb_rst_i (wb_rst_i),
    .bus      (bus)
  );

  always #5 clk = ~clk;

  int checks   = 0;
  int failures = 0;

  // Scoreboard: ppmd_o values expected on successive bit strobes.
  logic        exp_q[$];
  logic [31:0] crc_m;
  logic        ppmd_m;
  logic        txd_m;

  typedef struct {
    logic [3:0] sym;
    logic [1:0] dibit;
    logic       bad;
    logic       rst_after;
  } vec_t;

  vec_t tbl[9];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h expected=%h", name, act, exp);
    end
  endtask

  function automatic logic [31:0] crc_step(input logic [31:0] c, input logic b);
    crc_step = {c[30:0], 1'b0} ^ ((c[31] ^ b) ? 32'h04C11DB7 : 32'h0000_0000);
  endfunction

  task automatic model_reset();
    exp_q.delete();
    exp_q.push_back(1'b0);
    exp_q.push_back(1'b0);
    ppmd_m = 1'b0;
  endtask

  // One chip strobe cycle; called at a negedge, returns at the next negedge.
  task automatic chip_cycle(input logic c, input logic rx4, input logic clr);
    bus.fd_o           = c;
    bus.fir_rx8_enable = 1'b1;
    bus.fir_rx4_enable = rx4;
    bus.clrcrc         = clr;
    if (rx4) begin
      crc_m = clr ? 32'hFFFF_FFFF : crc_step(crc_m, ppmd_m);
      txd_m = ppmd_m;
      if (exp_q.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL scoreboard_underflow actual=empty expected=entry");
      end else begin
        ppmd_m = exp_q.pop_front();
      end
    end else if (clr) begin
      crc_m = 32'hFFFF_FFFF;
    end
    @(posedge clk);
    @(negedge clk);
    bus.fir_rx8_enable = 1'b0;
    bus.fir_rx4_enable = 1'b0;
    bus.clrcrc         = 1'b0;
    if (rx4) begin
      check("ppmd_o", {31'd0, bus.ppmd_o}, {31'd0, ppmd_m});
      check("txdout", {31'd0, bus.txdout}, {31'd0, txd_m});
      check("crc32_par_o", bus.crc32_par_o, crc_m);
    end
  endtask

  // Sends the first nchips chips of a symbol; bit strobes on chips 1 and 3.
  task automatic send_sym(input logic [3:0] sym, input logic [1:0] dibit, input int nchips, input logic clr_first);
    for (int k = 0; k < nchips; k++) begin
      chip_cycle(sym[3-k], (k % 2) == 1, clr_first && (k == 1));
    end
    if (nchips == 4) begin
      exp_q.push_back(dibit[0]);
      exp_q.push_back(dibit[1]);
    end
  endtask

  task automatic do_restart();
    bus.fir_rx_restart = 1'b1;
    @(posedge clk);
    @(negedge clk);
    bus.fir_rx_restart = 1'b0;
    model_reset();
  endtask

  // Byte 0x00 LSB-first plus complemented FCS, optionally with one data bit flipped.
  task automatic run_frame(input logic flip, input logic exp_ok);
    logic [39:0] fb;
    logic [31:0] c;
    logic [1:0]  idx;
    logic [3:0]  sym;
    c = 32'hFFFF_FFFF;
    for (int i = 0; i < 8; i++) begin
      fb[i] = 1'b0;
      c = crc_step(c, 1'b0);
    end
    for (int i = 0; i < 32; i++) fb[8+i] = ~c[31-i];
    if (flip) fb[3] = ~fb[3];
    do_restart();
    for (int j = 0; j < 20; j++) begin
      idx = {fb[2*j+1], fb[2*j]};
      sym = 4'b1000 >> idx;
      // First frame bit reaches the CRC on the second strobe of symbol 1.
      send_sym(sym, idx, 4, j == 1);
    end
    send_sym(4'b1000, 2'b00, 4, 1'b0);
    send_sym(4'b1000, 2'b00, 2, 1'b0);
    if (exp_ok) check("crc_residue", bus.crc32_par_o, 32'hC704DD7B);
    check(exp_ok ? "crc_ok_good" : "crc_ok_corrupt", {31'd0, bus.crc_ok}, {31'd0, exp_ok});
    do_restart();
  endtask

  initial begin
    logic chips[12];
    tbl[0] = '{4'b1000, 2'b00, 1'b0, 1'b0};
    tbl[1] = '{4'b0100, 2'b01, 1'b0, 1'b0};
    tbl[2] = '{4'b0010, 2'b10, 1'b0, 1'b0};
    tbl[3] = '{4'b0001, 2'b11, 1'b0, 1'b0};
    tbl[4] = '{4'b1100, 2'b00, 1'b1, 1'b0};
    tbl[5] = '{4'b1000, 2'b00, 1'b1, 1'b1};
    tbl[6] = '{4'b0000, 2'b00, 1'b1, 1'b1};
    tbl[7] = '{4'b1111, 2'b00, 1'b1, 1'b1};
    tbl[8] = '{4'b0001, 2'b11, 1'b0, 1'b0};
    chips = '{1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1};

    bus.fast_enable = 1'b0; bus.fir_rx8_enable = 1'b0; bus.fir_rx4_enable = 1'b0;
    bus.fir_rx_restart = 1'b0; bus.rx_i = 1'b0; bus.fd_o = 1'b0;
    bus.clrcrc = 1'b0; bus.crcndata = 1'b0; bus.bdcrc = 1'b0;
    wb_rst_i = 1'b1;
    crc_m = 32'hFFFF_FFFF; txd_m = 1'b0;
    model_reset();
    repeat (2) @(negedge clk);

    check("rst_bs_o", {31'd0, bus.bs_o}, 32'd0);
    check("rst_ppmd_o", {31'd0, bus.ppmd_o}, 32'd0);
    check("rst_bad_chip", {31'd0, bus.ppmd_bad_chip}, 32'd0);
    check("rst_txdout", {31'd0, bus.txdout}, 32'd0);
    check("rst_crc", bus.crc32_par_o, 32'hFFFF_FFFF);
    check("rst_crc_ok", {31'd0, bus.crc_ok}, 32'd0);
    wb_rst_i = 1'b0;
    @(negedge clk);

    // 4PPM decode table, including sticky bad-symbol behaviour
    for (int i = 0; i < 9; i++) begin
      send_sym(tbl[i].sym, tbl[i].dibit, 4, 1'b0);
      check("bad_chip", {31'd0, bus.ppmd_bad_chip}, {31'd0, tbl[i].bad});
      if (tbl[i].rst_after) begin
        do_restart();
        check("bad_after_restart", {31'd0, bus.ppmd_bad_chip}, 32'd0);
        check("ppmd_after_restart", {31'd0, bus.ppmd_o}, 32'd0);
      end
    end
    send_sym(4'b1000, 2'b00, 4, 1'b0);

    // CRC good frame and corrupted frame
    run_frame(1'b0, 1'b1);
    run_frame(1'b1, 1'b0);

    // Bit sync: chips of 4 strobes each, starting one strobe late
    bus.fast_enable = 1'b1;
    bus.rx_i = 1'b0;
    @(posedge clk); @(negedge clk);
    for (int c = 0; c < 12; c++) begin
      bus.rx_i = chips[c];
      repeat (4) begin
        @(posedge clk); @(negedge clk);
      end
      if (c >= 1) check("bs_o", {31'd0, bus.bs_o}, {31'd0, chips[c-1]});
    end
    bus.fast_enable = 1'b0;

    // Reset in the middle of a symbol with non-reset state present
    send_sym(4'b1100, 2'b00, 4, 1'b0);
    send_sym(4'b1000, 2'b00, 2, 1'b0);
    wb_rst_i = 1'b1;
    #1;
    check("midrst_bs_o", {31'd0, bus.bs_o}, 32'd0);
    check("midrst_ppmd_o", {31'd0, bus.ppmd_o}, 32'd0);
    check("midrst_bad_chip", {31'd0, bus.ppmd_bad_chip}, 32'd0);
    check("midrst_txdout", {31'd0, bus.txdout}, 32'd0);
    check("midrst_crc", bus.crc32_par_o, 32'hFFFF_FFFF);
    @(negedge clk);
    wb_rst_i = 1'b0;
    crc_m = 32'hFFFF_FFFF; txd_m = 1'b0;
    model_reset();
    @(negedge clk);
    send_sym(4'b0100, 2'b01, 4, 1'b0);
    send_sym(4'b1000, 2'b00, 4, 1'b0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
